// File: rtl/mac_accum_16.sv
`default_nettype none
// ============================================================================
// Module   : mac_accum_16
// Brief    : Streaming accumulator for multiplier products. Sums a burst that
//            is closed by a 'last' beat and returns sum, term count and
//            overflow flag over a valid/ready handshake.
//            Optional macro MAC_SATURATE_EN: clamp the sum instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accum_16 #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] c_ACC_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic               w_load_out;
  logic [ACC_W-1:0]   r_out_acc;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W:0]     w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_add;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_prod_ext = ACC_W'(in_product);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_carry    = w_sum[ACC_W];

`ifdef MAC_SATURATE_EN
  // Once clamped, any further non-zero term carries again, so the clamp holds.
  assign w_acc_add = w_carry ? c_ACC_MAX : w_sum[ACC_W-1:0];
`else
  assign w_acc_add = w_sum[ACC_W-1:0];
`endif

  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

  // Decoded from registered state only; out_ready never reaches in_ready.
  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_load_out      = 1'b0;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (clr) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end else if (in_valid) begin
          if (r_state == S_IDLE) begin
            w_acc_nxt = w_prod_ext;
            w_cnt_nxt = c_CNT_ONE;
            w_ovf_nxt = 1'b0;
          end else begin
            w_acc_nxt = w_acc_add;
            w_cnt_nxt = w_cnt_inc;
            w_ovf_nxt = r_ovf | w_carry;
          end
          if (in_last) begin
            w_state_nxt     = S_HOLD;
            w_load_out      = 1'b1;
            w_out_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_acc_nxt       = '0;
          w_cnt_nxt       = '0;
          w_ovf_nxt       = 1'b0;
          w_out_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_load_out) begin
        r_out_acc   <= w_acc_nxt;
        r_out_count <= w_cnt_nxt;
        r_out_ovf   <= w_ovf_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_accum_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accum_16
// Brief    : Directed and random bursts for mac_accum_16 against a burst-level
//            sum model. Define MAC_SATURATE_EN to match a saturating build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accum_16;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] in_product = '0;
  logic              in_last = 1'b0;
  logic              clr = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  int tests = 0;
  int fails = 0;

  // Model: products of the open burst, plus the result awaiting handshake.
  longint unsigned m_terms[$];
  bit              m_hold = 1'b0;
  longint unsigned e_acc = 0;
  longint unsigned e_cnt = 0;
  bit              e_ovf = 1'b0;

  always #5 clk = ~clk;

  mac_accum_16 #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_product(in_product),
    .in_last   (in_last),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void close_burst();
    longint unsigned total;
    longint unsigned lim;
    total = 0;
    foreach (m_terms[i]) total += m_terms[i];
    lim   = 64'd1 << ACC_W;
    e_ovf = (total >= lim);
`ifdef MAC_SATURATE_EN
    e_acc = e_ovf ? lim - 1 : total;
`else
    e_acc = total % lim;
`endif
    lim   = (64'd1 << CNT_W) - 1;
    e_cnt = (longint'(m_terms.size()) > lim) ? lim : longint'(m_terms.size());
    m_terms.delete();
    m_hold = 1'b1;
  endfunction

  // Called at a falling edge: check current outputs, drive one cycle, advance model.
  task automatic cycle(input bit v, input logic [PROD_W-1:0] p, input bit l,
                       input bit c, input bit r);
    check("in_ready", {63'd0, in_ready}, {63'd0, !m_hold});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_hold});
    if (m_hold) begin
      check("out_acc", 64'(out_acc), e_acc);
      check("out_count", 64'(out_count), e_cnt);
      check("out_ovf", {63'd0, out_ovf}, {63'd0, e_ovf});
    end
    in_valid   = v;
    in_product = p;
    in_last    = l;
    clr        = c;
    out_ready  = r;
    if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else if (c) begin
      m_terms.delete();
    end else if (v) begin
      m_terms.push_back(longint'(p));
      if (l) close_burst();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_out_acc"}, 64'(out_acc), 64'd0);
    check({tag, "_out_count"}, 64'(out_count), 64'd0);
    check({tag, "_out_ovf"}, {63'd0, out_ovf}, 64'd0);
  endtask

  initial begin
    logic [PROD_W-1:0] rp;

    // Power-on reset
    @(negedge clk);
    check_reset_outputs("por");
    check("por_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-term burst, then backpressure with ignored beats
    cycle(1, 16'h0001, 0, 0, 0);
    cycle(1, 16'h00FF, 0, 0, 0);
    cycle(1, 16'hFE01, 1, 0, 0);
    check("dir3_acc", 64'(out_acc), 64'h00FF01);
    check("dir3_count", 64'(out_count), 64'd3);
    check("dir3_ovf", {63'd0, out_ovf}, 64'd0);
    for (int i = 0; i < 5; i++) cycle(1, 16'h0F0F, 1, 0, 0);
    cycle(0, 16'h0000, 0, 0, 1);
    cycle(0, 16'h0000, 0, 0, 0);

    // Long burst: count saturates, sum overflows
    for (int i = 0; i < 300; i++) cycle(1, 16'hFFFF, (i == 299), 0, 0);
    check("ovf_count", 64'(out_count), 64'd255);
    check("ovf_flag", {63'd0, out_ovf}, 64'd1);
    cycle(0, 16'h0000, 0, 0, 1);

    // Abort after two beats (beat alongside clr dropped), then single-term burst
    cycle(1, 16'h1111, 0, 0, 0);
    cycle(1, 16'h2222, 0, 0, 0);
    cycle(1, 16'h5555, 1, 1, 0);
    cycle(1, 16'h1234, 1, 0, 0);
    check("clr_acc", 64'(out_acc), 64'h001234);
    check("clr_count", 64'(out_count), 64'd1);
    cycle(0, 16'h0000, 0, 1, 0);
    cycle(0, 16'h0000, 0, 0, 1);

    // Asynchronous reset in the middle of a burst
    cycle(1, 16'h0010, 0, 0, 0);
    cycle(1, 16'h0020, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_terms.delete();
    m_hold = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    cycle(1, 16'h0022, 1, 0, 0);
    check("midrst_count", 64'(out_count), 64'd1);
    cycle(0, 16'h0000, 0, 0, 1);

    // Random bursts of multiplier products with random gaps and backpressure
    for (int i = 0; i < 3000; i++) begin
      rp = 16'($urandom_range(0, 255)) * 16'($urandom_range(0, 255));
      cycle(($urandom_range(0, 9) < 7), rp, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 4; i++) cycle(0, 16'h0000, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
